// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: two-entry issue window feeding a 2-way pipeline.
// Steers the older/younger instruction of each fetched pair into slot A
// (ALU/branch) and slot B (ALU/load/store). Pairs that cannot issue together
// are serialised, and a one-cycle bubble is inserted on a load-use hazard.
module dual_issue_scheduler #(
  parameter int PCW = 64,
  parameter int IW  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fetch_valid,
  input  logic [PCW-1:0] fetch_pc,
  input  logic [IW-1:0]  fetch_instr0,
  input  logic [IW-1:0]  fetch_instr1,
  output logic           fetch_ready,
  input  logic           hold,
  input  logic           flush,
  output logic           issue_a_valid,
  output logic           issue_b_valid,
  output logic [IW-1:0]  issue_a_instr,
  output logic [IW-1:0]  issue_b_instr,
  output logic [PCW-1:0] issue_a_pc,
  output logic [PCW-1:0] issue_b_pc,
  output logic [15:0]    dual_cnt,
  output logic [15:0]    bubble_cnt
);

  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_PAIR   = 2'd1,
    S_SINGLE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [IW-1:0]  w0_instr, w0_instr_n, w1_instr, w1_instr_n;
  logic [PCW-1:0] w0_pc, w0_pc_n, w1_pc, w1_pc_n;

  // Destination of the load issued on slot B last cycle (valid only if rd != 0).
  logic           ld_valid, ld_valid_n;
  logic [4:0]     ld_rd, ld_rd_n;

  logic           a_valid_n, b_valid_n;
  logic [IW-1:0]  a_instr_n, b_instr_n;
  logic [PCW-1:0] a_pc_n, b_pc_n;
  logic           inc_dual, inc_bubble, drains, accept;

  logic           bubble, lu_w1, raw, waw, dual_ok, swap;

  function automatic logic is_br(input logic [IW-1:0] ins);
    return ins[6:0] == OP_BR;
  endfunction

  function automatic logic is_mem(input logic [IW-1:0] ins);
    return (ins[6:0] == OP_LD) || (ins[6:0] == OP_ST);
  endfunction

  function automatic logic is_ld(input logic [IW-1:0] ins);
    return ins[6:0] == OP_LD;
  endfunction

  // ALU and loads write rd; stores and branches use those bits as immediate.
  function automatic logic writes_rd(input logic [IW-1:0] ins);
    return !is_br(ins) && (ins[6:0] != OP_ST);
  endfunction

  function automatic logic reads_rs2(input logic [IW-1:0] ins);
    return (ins[6:0] == OP_REG) || (ins[6:0] == OP_ST) || (ins[6:0] == OP_BR);
  endfunction

  // True when ins reads architectural register r (x0 never counts).
  function automatic logic reads_reg(input logic [IW-1:0] ins, input logic [4:0] r);
    return (r != 5'd0) &&
           ((ins[19:15] == r) || (reads_rs2(ins) && (ins[24:20] == r)));
  endfunction

  // Hazard detection for the current window contents.
  always_comb begin
    bubble  = (state != S_EMPTY) && ld_valid && reads_reg(w0_instr, ld_rd);
    lu_w1   = ld_valid && reads_reg(w1_instr, ld_rd);
    raw     = writes_rd(w0_instr) && reads_reg(w1_instr, w0_instr[11:7]);
    waw     = writes_rd(w0_instr) && writes_rd(w1_instr) &&
              (w0_instr[11:7] == w1_instr[11:7]) && (w0_instr[11:7] != 5'd0);
    dual_ok = (state == S_PAIR) && !is_br(w0_instr) &&
              !(is_mem(w0_instr) && is_mem(w1_instr)) && !raw && !waw && !lu_w1;
    // Younger goes to A when it is a branch or the older needs the memory slot.
    swap    = is_br(w1_instr) || is_mem(w0_instr);
  end

  // Issue steering, window advance and fetch handshake.
  always_comb begin
    state_n    = state;
    w0_instr_n = w0_instr;
    w0_pc_n    = w0_pc;
    w1_instr_n = w1_instr;
    w1_pc_n    = w1_pc;
    a_valid_n  = 1'b0;
    a_instr_n  = '0;
    a_pc_n     = '0;
    b_valid_n  = 1'b0;
    b_instr_n  = '0;
    b_pc_n     = '0;
    inc_dual   = 1'b0;
    inc_bubble = 1'b0;
    drains     = 1'b0;

    case (state)
      S_EMPTY: drains = 1'b1;
      S_PAIR: begin
        if (bubble) begin
          inc_bubble = 1'b1;
        end else if (dual_ok) begin
          a_valid_n = 1'b1;
          b_valid_n = 1'b1;
          if (swap) begin
            a_instr_n = w1_instr;
            a_pc_n    = w1_pc;
            b_instr_n = w0_instr;
            b_pc_n    = w0_pc;
          end else begin
            a_instr_n = w0_instr;
            a_pc_n    = w0_pc;
            b_instr_n = w1_instr;
            b_pc_n    = w1_pc;
          end
          inc_dual = 1'b1;
          drains   = 1'b1;
          state_n  = S_EMPTY;
        end else begin
          if (is_mem(w0_instr)) begin
            b_valid_n = 1'b1;
            b_instr_n = w0_instr;
            b_pc_n    = w0_pc;
          end else begin
            a_valid_n = 1'b1;
            a_instr_n = w0_instr;
            a_pc_n    = w0_pc;
          end
          w0_instr_n = w1_instr;
          w0_pc_n    = w1_pc;
          state_n    = S_SINGLE;
        end
      end
      S_SINGLE: begin
        if (bubble) begin
          inc_bubble = 1'b1;
        end else begin
          if (is_mem(w0_instr)) begin
            b_valid_n = 1'b1;
            b_instr_n = w0_instr;
            b_pc_n    = w0_pc;
          end else begin
            a_valid_n = 1'b1;
            a_instr_n = w0_instr;
            a_pc_n    = w0_pc;
          end
          drains  = 1'b1;
          state_n = S_EMPTY;
        end
      end
      default: state_n = S_EMPTY;
    endcase

    ld_valid_n = b_valid_n && is_ld(b_instr_n) && (b_instr_n[11:7] != 5'd0);
    ld_rd_n    = ld_valid_n ? b_instr_n[11:7] : 5'd0;

    fetch_ready = !rst && !hold && !flush && drains;
    accept      = fetch_valid && fetch_ready;
    if (accept) begin
      w0_instr_n = fetch_instr0;
      w0_pc_n    = fetch_pc;
      w1_instr_n = fetch_instr1;
      w1_pc_n    = fetch_pc + PCW'(4);
      state_n    = S_PAIR;
    end
  end

  // State, window, issue registers and counters; flush beats hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_EMPTY;
      w0_instr      <= '0;
      w0_pc         <= '0;
      w1_instr      <= '0;
      w1_pc         <= '0;
      ld_valid      <= 1'b0;
      ld_rd         <= 5'd0;
      issue_a_valid <= 1'b0;
      issue_a_instr <= '0;
      issue_a_pc    <= '0;
      issue_b_valid <= 1'b0;
      issue_b_instr <= '0;
      issue_b_pc    <= '0;
      dual_cnt      <= 16'd0;
      bubble_cnt    <= 16'd0;
    end else if (flush) begin
      state         <= S_EMPTY;
      ld_valid      <= 1'b0;
      ld_rd         <= 5'd0;
      issue_a_valid <= 1'b0;
      issue_a_instr <= '0;
      issue_a_pc    <= '0;
      issue_b_valid <= 1'b0;
      issue_b_instr <= '0;
      issue_b_pc    <= '0;
    end else if (!hold) begin
      state         <= state_n;
      w0_instr      <= w0_instr_n;
      w0_pc         <= w0_pc_n;
      w1_instr      <= w1_instr_n;
      w1_pc         <= w1_pc_n;
      ld_valid      <= ld_valid_n;
      ld_rd         <= ld_rd_n;
      issue_a_valid <= a_valid_n;
      issue_a_instr <= a_instr_n;
      issue_a_pc    <= a_pc_n;
      issue_b_valid <= b_valid_n;
      issue_b_instr <= b_instr_n;
      issue_b_pc    <= b_pc_n;
      if (inc_dual && (dual_cnt != 16'hFFFF))
        dual_cnt <= dual_cnt + 16'd1;
      if (inc_bubble && (bubble_cnt != 16'hFFFF))
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule
